add_serial: RTL and testbench
=============================

# add_serial

Multi-cycle adder for operands wider than 4 bits. It reuses a single `add4` nibble adder over `NIBBLES` consecutive cycles, registering the carry between nibbles. It sits between an operand producer and a result consumer. It feeds `add4` one nibble pair per cycle and consumes the `add4` sum and carry-out to build the wide result. Both sides use valid/ready handshakes.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; W = 4*NIBBLES bits. Legal range 1..16.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `in_valid`: input, 1 bit. Operand set a/b/cin is valid.
- `in_ready`: output, 1 bit. Block can accept operands.
- `a`: input, W bits. Operand A, unsigned.
- `b`: input, W bits. Operand B, unsigned.
- `cin`: input, 1 bit. Carry into nibble 0.
- `out_valid`: output, 1 bit. sum/cout hold a completed result.
- `out_ready`: input, 1 bit. Consumer accepts the result.
- `sum`: output, W bits. (a + b + cin) mod 2^W.
- `cout`: output, 1 bit. Carry out of the top nibble.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1 (0 while `reset` is high).
  - On `in_valid && in_ready`, capture a, b into operand shift registers, load carry register with `cin`, clear nibble counter, go to RUN.
  - When `in_valid` is low, the state holds.
- RUN:
  - `add4` inputs are the low nibbles of the A/B shift registers plus the carry register.
  - Each cycle, the `add4` sum enters the top nibble of the sum shift register, which shifts right by 4. The A/B registers also shift right by 4.
  - The `add4` carry-out is stored to the carry register and the counter increments.
  - When counter == NIBBLES-1, take the final step, write the final carry to `cout`, and go to DONE.
- DONE:
  - `out_valid`=1.
  - `sum` and `cout` stay stable until `out_valid && out_ready`, then go to IDLE.
  - `in_valid` is ignored in RUN and DONE (`in_ready`=0).
- Arithmetic is unsigned, with no overflow flag. `cout` is bit W of the full (W+1)-bit sum.
- After a result is consumed, `sum` and `cout` keep their last values until the next result is written. Only `out_valid` qualifies them.
- Reset (any state, including mid-RUN or DONE) takes effect on the next edge:
  - State returns to IDLE and the in-flight operation is discarded.
  - `out_valid`=0, `sum`=0, `cout`=0, carry register=0, counter=0, operand registers=0.

## Timing
- Accept edge E0 moves the state to RUN.
- Nibble k is computed on edge E(k+1), for k = 0..NIBBLES-1.
- `out_valid` rises after edge E(NIBBLES), so latency from accept to `out_valid` is exactly NIBBLES cycles.
- The earliest return to IDLE is one cycle later, when `out_ready` is already high.
- Minimum initiation interval is NIBBLES+2 cycles. There is no overlap of accept and result handshakes.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- The `add4` path is the only combinational arithmetic: one 4-bit ripple per cycle.

## Structure
- Shared package `add_pkg`: state enum `add_state_t` {IDLE, RUN, DONE} and constant `NIBBLE_W` = 4.
- Exactly one `add4` instance as the sub-module. No other arithmetic; the counter increment is the only `+`.
- Counter width is $clog2(NIBBLES), minimum 1 bit.

## Test plan
- NIBBLES=4, a=0x1234, b=0x4321, cin=0:
  - `sum`=0x5555, `cout`=0.
  - `out_valid` rises exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0:
  - `sum`=0x0000, `cout`=1.
  - Carry ripples through all 4 nibble steps.
- a=0xFFFF, b=0x0000, cin=1:
  - `sum`=0x0000, `cout`=1.
- Result stall: hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 with a=0x0001, b=0x0001.
  - `sum`/`cout` hold the previous result.
  - `in_ready`=0 and the new operands are not captured.
  - After `out_ready` pulses, the next accept produces 0x0002.
- Reset mid-operation: assert `reset` on the 2nd RUN cycle of 0x00F0+0x0F00.
  - Next cycle: `out_valid`=0, `sum`=0, `cout`=0, `in_ready`=1.
  - A new operation 0x0003+0x0004 then yields 0x0007.
- NIBBLES=1, a=0xF, b=0x1, cin=1:
  - `sum`=0x1, `cout`=1.
  - `out_valid` rises 1 cycle after accept.

Source files
------------

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types and constants for the nibble-serial adder
//
// Contents:
//   add_state_t : controller state (IDLE, RUN, DONE)
//   NIBBLE_W    : width of one nibble step (4)
package add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

endpackage : add_pkg

// File: rtl/add_serial_add4.sv
// rtl/add_serial_add4.sv - 4-bit ripple-carry nibble adder
//
// Ports:
//   a, b  : nibble operands
//   cin   : carry in
//   sum   : nibble sum
//   cout  : carry out of bit 3
module add4
  import add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  // Explicit full-adder chain; the carry is a procedural variable so the
  // ripple is evaluated in one pass without a self-referencing vector.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule : add4

// File: rtl/add_serial.sv
// rtl/add_serial.sv - multi-cycle wide adder built from one nibble adder
//
// Parameters:
//   NIBBLES   : operand width in nibbles (1..16), W = 4*NIBBLES
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   in_valid  : a/b/cin valid
//   in_ready  : block accepts operands (IDLE, not in reset)
//   a, b      : W-bit unsigned operands
//   cin       : carry into nibble 0
//   out_valid : sum/cout hold a completed result
//   out_ready : consumer takes the result
//   sum       : (a + b + cin) mod 2^W
//   cout      : bit W of the full sum
module add_serial
  import add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  input  logic                         cin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  add_state_t     state;
  logic [W-1:0]   a_sr;
  logic [W-1:0]   b_sr;
  logic [W-1:0]   sum_sr;
  logic [W-1:0]   sum_q;
  logic           cout_q;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic [NIBBLE_W-1:0] s4;
  logic                c4;
  logic [W-1:0]        sum_next;

  add4 u_add4 (
    .a    (a_sr[NIBBLE_W-1:0]),
    .b    (b_sr[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (s4),
    .cout (c4)
  );

  // The newest nibble enters at the top, so after NIBBLES steps nibble 0
  // has been pushed down to the bottom of the register.
  generate
    if (NIBBLES == 1) begin : g_one
      assign sum_next = s4;
    end else begin : g_multi
      assign sum_next = {s4, sum_sr[W-1:NIBBLE_W]};
    end
  endgenerate

  // Handshake outputs depend only on registered state; in_ready is also
  // held low while reset is asserted.
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          a_sr   <= a_sr >> NIBBLE_W;
          b_sr   <= b_sr >> NIBBLE_W;
          sum_sr <= sum_next;
          carry  <= c4;
          if (cnt == LAST) begin
            // Final nibble: publish the result directly from this step so
            // sum/cout only change when a complete result is available.
            sum_q  <= sum_next;
            cout_q <= c4;
            cnt    <= '0;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : add_serial

// File: tb/tb_add_serial.sv
// tb/tb_add_serial.sv - self-checking bench for add_serial (NIBBLES=4 and 1)
module tb_add_serial;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
  logic [3:0]  a1, b1, sum1;

  int errors = 0;
  int checks = 0;

  logic [16:0] sb[$];

  always #5 clk = ~clk;

  add_serial #(.NIBBLES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  add_serial #(.NIBBLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%b want=0", in_ready); end
    checks++;
    if ({out_valid, cout, sum} !== 18'h0) begin
      errors++; $display("FAIL reset_outputs got ov=%b cout=%b sum=%h want 0/0/0000", out_valid, cout, sum);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high got=%b want=1", in_ready); end
  endtask

  // Drives one operation on the 4-nibble DUT, checks latency and result;
  // with consume=0 the result is left pending in DONE.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input bit consume, input string name);
    int lat;
    logic [16:0] exp;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got=%b want=1", name, in_ready); end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    sb.push_back({1'b0, ta} + {1'b0, tb_} + {16'h0, tc});
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL %s_latency got=%0d want=4", name, lat); end
    exp = (sb.size() > 0) ? sb.pop_front() : 17'h1_ffff;
    checks++;
    if ({cout, sum} !== exp) begin
      errors++; $display("FAIL %s_result got cout=%b sum=%h want cout=%b sum=%h", name, cout, sum, exp[16], exp[15:0]);
    end
    if (consume) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL %s_release got ov=%b ir=%b want ov=0 ir=1", name, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, "basic_5555");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, "ripple_ffff_1");
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b1, "ripple_cin");
  endtask

  task automatic test_stall();
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "stall_prev");
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== 17'h00100) begin
        errors++;
        $display("FAIL stall_hold_%0d got ov=%b ir=%b cout=%b sum=%h want ov=1 ir=0 cout=0 sum=0100",
                 i, out_valid, in_ready, cout, sum);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || {cout, sum} !== 17'h00100) begin
      errors++; $display("FAIL stall_after_consume got ov=%b sum=%h want ov=0 sum=0100", out_valid, sum);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b1, "stall_next");
  endtask

  task automatic test_reset_mid();
    a = 16'h00F0; b = 16'h0F00; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({out_valid, cout, sum} !== 18'h0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got ov=%b cout=%b sum=%h ir=%b want 0/0/0000/0",
                         out_valid, cout, sum, in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b want=1", in_ready); end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0) begin
      errors++; $display("FAIL midreset_discard got ov=%b sum=%h want ov=0 sum=0000", out_valid, sum);
    end
    run_op(16'h0003, 16'h0004, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_nibbles1();
    int lat;
    logic [4:0] exp;
    logic [4:0] q1[$];
    a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1; in_valid1 = 1'b1;
    checks++;
    if (in_ready1 !== 1'b1) begin errors++; $display("FAIL n1_ready got=%b want=1", in_ready1); end
    q1.push_back({1'b0, a1} + {1'b0, b1} + {4'h0, cin1});
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (out_valid1 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL n1_latency got=%0d want=1", lat); end
    exp = q1.pop_front();
    checks++;
    if ({cout1, sum1} !== exp) begin
      errors++; $display("FAIL n1_result got cout=%b sum=%h want cout=%b sum=%h", cout1, sum1, exp[4], exp[3:0]);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL n1_release got ov=%b ir=%b want ov=0 ir=1", out_valid1, in_ready1);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, last_acc = -1, results = 0;
    logic acc, done;
    logic [16:0] obs, exp, cur;
    out_ready = 1'b1;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    in_valid = 1'b1;
    while (results < 6 && cyc < 300) begin
      acc  = in_valid && in_ready;
      done = out_valid && out_ready;
      obs  = {cout, sum};
      cur  = {1'b0, a} + {1'b0, b} + {16'h0, cin};
      tick();
      cyc++;
      if (acc) begin
        sb.push_back(cur);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 6) begin
            errors++; $display("FAIL b2b_interval got=%0d want=6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      end
      if (done) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 17'h1_ffff;
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL b2b_result_%0d got %h want %h", results, obs, exp);
        end
        results++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (results < 6) begin errors++; $display("FAIL b2b_timeout got=%0d results want=6", results); end
    tick();
    tick();
    sb.delete();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_nibbles1();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_add_serial
